polinomio_horner: RTL and testbench

Parametrised sequential polynomial evaluator: computes P(X) = c_g·X^g + … + c_1·X + c_0 using Horner's rule, one multiply-accumulate per clock. It generalises the fixed second-degree operative/control block (A·X² + B·X + C) to a configurable width, a maximum degree set at elaboration, and a degree selected per operation. It keeps the inicio/pronto/overflow handshake style and is intended as the arithmetic core that top-level projects instantiate.

---
 rtl/polinomio_horner.sv | 137 +++++++++++++
 tb/tb_polinomio_horner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/polinomio_horner.sv
// Sequential polynomial evaluator using Horner's rule, one multiply-accumulate per clock.
// Degree is chosen per operation and clamped to MAX_GRAU; results wrap modulo 2^WIDTH.
module polinomio_horner #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_GRAU = 2
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic                          inicio,
    input  logic [3:0]                    grau,
    input  logic [WIDTH-1:0]              X,
    input  logic [(MAX_GRAU+1)*WIDTH-1:0] coefs,
    output logic [WIDTH-1:0]              Resultado,
    output logic                          pronto,
    output logic                          ocupado,
    output logic                          overflow
);

    localparam int unsigned NC = MAX_GRAU + 1;
    localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] coef_q [NC];
    logic [WIDTH-1:0] coef_d [NC];
    logic [3:0]       idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;
    logic             ovf_out_q, ovf_out_d;

    logic [WIDTH-1:0] coef_in_c [NC];
    logic [3:0]       g_c;
    logic [PW-1:0]    prod_c;
    logic [SW-1:0]    sum_c;
    logic             step_ovf_c;

    // Unpack the coefficient bus and clamp the requested degree.
    always_comb begin
        for (int unsigned i = 0; i < NC; i++) begin
            coef_in_c[i] = coefs[i*WIDTH +: WIDTH];
        end
        g_c = (grau > 4'(MAX_GRAU)) ? 4'(MAX_GRAU) : grau;
    end

    // One Horner step: acc*X + c_(idx-1), overflow from the high product half or the carry.
    always_comb begin
        prod_c     = PW'(acc_q) * PW'(x_q);
        sum_c      = SW'(prod_c[WIDTH-1:0]) + SW'(coef_q[IW'(idx_q - 4'd1)]);
        step_ovf_c = (|prod_c[PW-1:WIDTH]) | sum_c[WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        acc_d     = acc_q;
        coef_d    = coef_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        pronto_d  = 1'b0;
        ovf_out_d = ovf_out_q;

        case (state_q)
            IDLE: begin
                if (inicio) begin
                    x_d    = X;
                    coef_d = coef_in_c;
                    acc_d  = coef_in_c[IW'(g_c)];
                    idx_d  = g_c;
                    ovf_d  = 1'b0;
                    if (g_c == 4'd0) begin
                        state_d   = DONE;
                        res_d     = coef_in_c[0];
                        ovf_out_d = 1'b0;
                        pronto_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = sum_c[WIDTH-1:0];
                idx_d = idx_q - 4'd1;
                ovf_d = ovf_q | step_ovf_c;
                if (idx_q == 4'd1) begin
                    state_d   = DONE;
                    res_d     = sum_c[WIDTH-1:0];
                    ovf_out_d = ovf_q | step_ovf_c;
                    pronto_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            acc_q     <= '0;
            coef_q    <= '{default: '0};
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            acc_q     <= acc_d;
            coef_q    <= coef_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign Resultado = res_q;
    assign pronto    = pronto_q;
    assign ocupado   = ocupado_q;
    assign overflow  = ovf_out_q;

endmodule

// File: tb/tb_polinomio_horner.sv
// Directed bench for polinomio_horner: one instance at MAX_GRAU=2, one at MAX_GRAU=4.
module tb_polinomio_horner;

    logic        ck;
    logic        rst;

    logic        inicio2, inicio4;
    logic [3:0]  grau2, grau4;
    logic [15:0] x2, x4;
    logic [47:0] coefs2;
    logic [79:0] coefs4;
    logic [15:0] res2, res4;
    logic        pronto2, pronto4, ocup2, ocup4, ovf2, ovf4;

    int tests;
    int fails;

    polinomio_horner #(.WIDTH(16), .MAX_GRAU(2)) dut (
        .ck(ck), .rst(rst), .inicio(inicio2), .grau(grau2), .X(x2), .coefs(coefs2),
        .Resultado(res2), .pronto(pronto2), .ocupado(ocup2), .overflow(ovf2)
    );

    polinomio_horner #(.WIDTH(16), .MAX_GRAU(4)) dut4 (
        .ck(ck), .rst(rst), .inicio(inicio4), .grau(grau4), .X(x4), .coefs(coefs4),
        .Resultado(res4), .pronto(pronto4), .ocupado(ocup4), .overflow(ovf4)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Starts one operation and counts edges until pronto (bounded at 40).
    task automatic launch(input bit use4, input logic [3:0] g, input logic [15:0] x,
                          input logic [79:0] cf, output int edges);
        if (use4) begin
            grau4 = g; x4 = x; coefs4 = cf; inicio4 = 1'b1;
        end else begin
            grau2 = g; x2 = x; coefs2 = cf[47:0]; inicio2 = 1'b1;
        end
        @(posedge ck); #1;
        inicio2 = 1'b0;
        inicio4 = 1'b0;
        edges = 1;
        while (((use4 ? pronto4 : pronto2) !== 1'b1) && edges < 40) begin
            @(posedge ck); #1;
            edges++;
        end
    endtask

    localparam logic [79:0] BASE = {32'd0, 16'd38, 16'd333, 16'd4902};

    task automatic test_reset;
        #1;
        tests++; if (res2 !== 16'd0)  begin fails++; $display("FAIL reset_res got=%0d exp=0", res2); end
        tests++; if (pronto2 !== 1'b0) begin fails++; $display("FAIL reset_pronto got=%b exp=0", pronto2); end
        tests++; if (ocup2 !== 1'b0)   begin fails++; $display("FAIL reset_ocupado got=%b exp=0", ocup2); end
        tests++; if (ovf2 !== 1'b0)    begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf2); end
        @(posedge ck); #1;
        rst = 1'b0;
    endtask

    task automatic test_baseline;
        int e;
        launch(1'b0, 4'd2, 16'd23, BASE, e);
        tests++; if (e != 3)            begin fails++; $display("FAIL base_latency got=%0d exp=3", e); end
        tests++; if (res2 !== 16'd32663) begin fails++; $display("FAIL base_res got=%0d exp=32663", res2); end
        tests++; if (ovf2 !== 1'b0)      begin fails++; $display("FAIL base_ovf got=%b exp=0", ovf2); end
        tests++; if (ocup2 !== 1'b1)     begin fails++; $display("FAIL base_ocup_done got=%b exp=1", ocup2); end
        @(posedge ck); #1;
        tests++; if (pronto2 !== 1'b0)   begin fails++; $display("FAIL base_pronto_width got=%b exp=0", pronto2); end
        tests++; if (ocup2 !== 1'b0)     begin fails++; $display("FAIL base_ocup_idle got=%b exp=0", ocup2); end
    endtask

    task automatic test_degree0;
        int e;
        launch(1'b0, 4'd0, 16'd99, {64'd0, 16'h1234}, e);
        tests++; if (e != 1)             begin fails++; $display("FAIL deg0_latency got=%0d exp=1", e); end
        tests++; if (res2 !== 16'h1234)  begin fails++; $display("FAIL deg0_res got=%h exp=1234", res2); end
        tests++; if (ovf2 !== 1'b0)      begin fails++; $display("FAIL deg0_ovf got=%b exp=0", ovf2); end
        @(posedge ck); #1;
    endtask

    task automatic test_overflow;
        int e;
        launch(1'b0, 4'd2, 16'h0100, {32'd0, 16'h0100, 16'd0, 16'd0}, e);
        tests++; if (res2 !== 16'h0000) begin fails++; $display("FAIL ovf_mul_res got=%h exp=0000", res2); end
        tests++; if (ovf2 !== 1'b1)     begin fails++; $display("FAIL ovf_mul_flag got=%b exp=1", ovf2); end
        @(posedge ck); #1;
        launch(1'b0, 4'd1, 16'hFFFF, {48'd0, 16'd1, 16'd1}, e);
        tests++; if (e != 2)            begin fails++; $display("FAIL ovf_add_latency got=%0d exp=2", e); end
        tests++; if (res2 !== 16'h0000) begin fails++; $display("FAIL ovf_add_res got=%h exp=0000", res2); end
        tests++; if (ovf2 !== 1'b1)     begin fails++; $display("FAIL ovf_add_flag got=%b exp=1", ovf2); end
        @(posedge ck); #1;
        launch(1'b0, 4'd2, 16'd23, BASE, e);
        tests++; if (ovf2 !== 1'b0)      begin fails++; $display("FAIL ovf_clear got=%b exp=0", ovf2); end
        tests++; if (res2 !== 16'd32663) begin fails++; $display("FAIL ovf_clear_res got=%0d exp=32663", res2); end
        @(posedge ck); #1;
    endtask

    task automatic test_clamp;
        int e;
        launch(1'b0, 4'd7, 16'd23, BASE, e);
        tests++; if (e != 3)             begin fails++; $display("FAIL clamp_latency got=%0d exp=3", e); end
        tests++; if (res2 !== 16'd32663) begin fails++; $display("FAIL clamp_res got=%0d exp=32663", res2); end
        @(posedge ck); #1;
        launch(1'b1, 4'd4, 16'd2, {16'd1, 16'd1, 16'd1, 16'd1, 16'd1}, e);
        tests++; if (e != 5)          begin fails++; $display("FAIL deep_latency got=%0d exp=5", e); end
        tests++; if (res4 !== 16'd31) begin fails++; $display("FAIL deep_res got=%0d exp=31", res4); end
        tests++; if (ovf4 !== 1'b0)   begin fails++; $display("FAIL deep_ovf got=%b exp=0", ovf4); end
        @(posedge ck); #1;
    endtask

    task automatic test_busy;
        int pulses;
        grau2 = 4'd2; x2 = 16'd23; coefs2 = BASE[47:0]; inicio2 = 1'b1;
        @(posedge ck); #1;
        inicio2 = 1'b0;
        tests++; if (ocup2 !== 1'b1) begin fails++; $display("FAIL busy_ocup got=%b exp=1", ocup2); end
        x2 = 16'd5; coefs2 = {16'd7, 16'd7, 16'd7}; grau2 = 4'd1; inicio2 = 1'b1;
        @(posedge ck); #1;
        @(posedge ck); #1;
        tests++; if (pronto2 !== 1'b1)   begin fails++; $display("FAIL busy_pronto got=%b exp=1", pronto2); end
        tests++; if (res2 !== 16'd32663) begin fails++; $display("FAIL busy_res got=%0d exp=32663", res2); end
        inicio2 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge ck); #1;
            if (pronto2 === 1'b1) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL busy_not_queued got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid;
        int e;
        int pulses;
        launch(1'b0, 4'd1, 16'h0100, {48'd0, 16'h0100, 16'd5}, e);
        tests++; if (res2 !== 16'd5) begin fails++; $display("FAIL pre_rst_res got=%0d exp=5", res2); end
        tests++; if (ovf2 !== 1'b1)  begin fails++; $display("FAIL pre_rst_ovf got=%b exp=1", ovf2); end
        @(posedge ck); #1;
        grau2 = 4'd2; x2 = 16'd23; coefs2 = BASE[47:0]; inicio2 = 1'b1;
        @(posedge ck); #1;
        inicio2 = 1'b0;
        @(posedge ck); #2;
        rst = 1'b1;
        #1;
        tests++; if (res2 !== 16'd0)  begin fails++; $display("FAIL rst_mid_res got=%0d exp=0", res2); end
        tests++; if (ovf2 !== 1'b0)   begin fails++; $display("FAIL rst_mid_ovf got=%b exp=0", ovf2); end
        tests++; if (ocup2 !== 1'b0)  begin fails++; $display("FAIL rst_mid_ocup got=%b exp=0", ocup2); end
        tests++; if (pronto2 !== 1'b0) begin fails++; $display("FAIL rst_mid_pronto got=%b exp=0", pronto2); end
        @(posedge ck); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge ck); #1;
            if (pronto2 === 1'b1) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL rst_no_pronto got=%0d exp=0", pulses); end
        launch(1'b0, 4'd2, 16'd23, BASE, e);
        tests++; if (e != 3)             begin fails++; $display("FAIL post_rst_latency got=%0d exp=3", e); end
        tests++; if (res2 !== 16'd32663) begin fails++; $display("FAIL post_rst_res got=%0d exp=32663", res2); end
        @(posedge ck); #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        inicio2 = 1'b0; inicio4 = 1'b0;
        grau2 = '0; grau4 = '0;
        x2 = '0; x4 = '0;
        coefs2 = '0; coefs4 = '0;
        test_reset;
        test_baseline;
        test_degree0;
        test_overflow;
        test_clamp;
        test_busy;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
